// File: rtl/cache_block_writer.sv
// One-block data-cache write side: CPU byte stores, whole-block refill, and
// byte-serial write-back of a dirty block over a valid/ready handshake.
module cache_block_writer #(
  parameter int DATA_W = 8,
  parameter int TAG_W  = 3
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                wr_en,
  input  logic [1:0]          wr_offset,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                fill_valid,
  input  logic [4*DATA_W-1:0] fill_data,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic                evict_start,
  input  logic                evict_ready,
  output logic                evict_valid,
  output logic [DATA_W-1:0]   evict_data,
  output logic [1:0]          evict_offset,
  output logic [TAG_W-1:0]    evict_tag,
  output logic                evict_done,
  output logic                busy,
  output logic [4*DATA_W-1:0] block_data,
  output logic [TAG_W-1:0]    block_tag,
  output logic                valid,
  output logic                dirty
);

  localparam int BLK_W = 4 * DATA_W;

  typedef enum logic {IDLE, EVICT} state_t;

  state_t              state, state_nx;
  logic [BLK_W-1:0]    blk_nx;
  logic [TAG_W-1:0]    tag_nx, ev_tag_nx;
  logic                valid_nx, dirty_nx, ev_valid_nx, ev_done_nx;
  logic [1:0]          cnt, cnt_nx;
  logic [DATA_W-1:0]   ev_data_nx;

  function automatic logic [DATA_W-1:0] byte_sel(input logic [BLK_W-1:0] b,
                                                 input logic [1:0] i);
    return b[int'(i)*DATA_W +: DATA_W];
  endfunction

  assign busy         = (state != IDLE);
  assign evict_offset = cnt;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx    = state;
    blk_nx      = block_data;
    tag_nx      = block_tag;
    valid_nx    = valid;
    dirty_nx    = dirty;
    cnt_nx      = cnt;
    ev_valid_nx = evict_valid;
    ev_data_nx  = evict_data;
    ev_tag_nx   = evict_tag;
    ev_done_nx  = 1'b0;
    case (state)
      IDLE: begin
        if (fill_valid) begin
          blk_nx   = fill_data;
          tag_nx   = fill_tag;
          valid_nx = 1'b1;
          dirty_nx = 1'b0;
        end else if (evict_start) begin
          // A clean or empty block needs no write-back; just acknowledge it.
          if (valid && dirty) begin
            state_nx    = EVICT;
            cnt_nx      = 2'd0;
            ev_valid_nx = 1'b1;
            ev_data_nx  = byte_sel(block_data, 2'd0);
            ev_tag_nx   = block_tag;
          end else begin
            ev_done_nx = 1'b1;
          end
        end else if (wr_en && valid) begin
          blk_nx[int'(wr_offset)*DATA_W +: DATA_W] = wr_data;
          dirty_nx = 1'b1;
        end
      end
      EVICT: begin
        // Outputs only advance on an accepted byte, so they hold under back-pressure.
        if (evict_valid && evict_ready) begin
          if (cnt == 2'd3) begin
            state_nx    = IDLE;
            cnt_nx      = 2'd0;
            ev_valid_nx = 1'b0;
            dirty_nx    = 1'b0;
            ev_done_nx  = 1'b1;
          end else begin
            cnt_nx     = cnt + 2'd1;
            ev_data_nx = byte_sel(block_data, cnt + 2'd1);
          end
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      block_data  <= '0;
      block_tag   <= '0;
      valid       <= 1'b0;
      dirty       <= 1'b0;
      cnt         <= 2'd0;
      evict_valid <= 1'b0;
      evict_data  <= '0;
      evict_tag   <= '0;
      evict_done  <= 1'b0;
    end else begin
      block_data  <= blk_nx;
      block_tag   <= tag_nx;
      valid       <= valid_nx;
      dirty       <= dirty_nx;
      cnt         <= cnt_nx;
      evict_valid <= ev_valid_nx;
      evict_data  <= ev_data_nx;
      evict_tag   <= ev_tag_nx;
      evict_done  <= ev_done_nx;
    end
  end

endmodule

// File: tb/tb_cache_block_writer.sv
// Randomized bench for cache_block_writer against a byte-array / queue model.
module tb_cache_block_writer;

  localparam int DATA_W = 8;
  localparam int TAG_W  = 3;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              wr_en;
  logic [1:0]        wr_offset;
  logic [7:0]        wr_data;
  logic              fill_valid;
  logic [31:0]       fill_data;
  logic [2:0]        fill_tag;
  logic              evict_start;
  logic              evict_ready;
  logic              evict_valid;
  logic [7:0]        evict_data;
  logic [1:0]        evict_offset;
  logic [2:0]        evict_tag;
  logic              evict_done;
  logic              busy;
  logic [31:0]       block_data;
  logic [2:0]        block_tag;
  logic              valid;
  logic              dirty;

  cache_block_writer #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset_n(reset_n),
    .wr_en(wr_en), .wr_offset(wr_offset), .wr_data(wr_data),
    .fill_valid(fill_valid), .fill_data(fill_data), .fill_tag(fill_tag),
    .evict_start(evict_start), .evict_ready(evict_ready),
    .evict_valid(evict_valid), .evict_data(evict_data),
    .evict_offset(evict_offset), .evict_tag(evict_tag),
    .evict_done(evict_done), .busy(busy),
    .block_data(block_data), .block_tag(block_tag),
    .valid(valid), .dirty(dirty)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [1:0] off;
    logic [7:0] dat;
  } ev_t;

  // Reference model: four bytes, tag, flags, and the queue of bytes still owed.
  logic [7:0] mb [4];
  logic [2:0] mt, m_etag;
  logic       mv, md, m_done;
  ev_t        q[$];
  int         checks = 0;
  int         errors = 0;
  int         done_pulses = 0;
  int         ev_bytes = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] m_block();
    return {mb[3], mb[2], mb[1], mb[0]};
  endfunction

  task automatic model_reset();
    for (int k = 0; k < 4; k++) mb[k] = 8'h00;
    mt = '0; mv = 1'b0; md = 1'b0; m_done = 1'b0;
    q.delete();
  endtask

  task automatic check_all(input string tag);
    check({tag, ".block"}, block_data, m_block());
    check({tag, ".tag"},   block_tag, mt);
    check({tag, ".valid"}, valid, mv);
    check({tag, ".dirty"}, dirty, md);
    check({tag, ".busy"},  busy, q.size() != 0);
    check({tag, ".evv"},   evict_valid, q.size() != 0);
    check({tag, ".done"},  evict_done, m_done);
    if (q.size() != 0) begin
      check({tag, ".evdata"}, evict_data, q[0].dat);
      check({tag, ".evoff"},  evict_offset, q[0].off);
      check({tag, ".evtag"},  evict_tag, m_etag);
    end
  endtask

  // One clock: inputs are already applied with the clock low.
  task automatic step(input string tag);
    m_done = 1'b0;
    if (q.size() != 0) begin
      if (evict_ready) begin
        void'(q.pop_front());
        ev_bytes++;
        if (q.size() == 0) begin
          md = 1'b0;
          m_done = 1'b1;
        end
      end
    end else if (fill_valid) begin
      for (int k = 0; k < 4; k++) mb[k] = fill_data[8*k +: 8];
      mt = fill_tag; mv = 1'b1; md = 1'b0;
    end else if (evict_start) begin
      if (mv && md) begin
        for (int k = 0; k < 4; k++) q.push_back('{off: 2'(k), dat: mb[k]});
        m_etag = mt;
      end else begin
        m_done = 1'b1;
      end
    end else if (wr_en && mv) begin
      mb[wr_offset] = wr_data;
      md = 1'b1;
    end
    @(posedge clock);
    #1;
    if (evict_done) done_pulses++;
    check_all(tag);
    @(negedge clock);
  endtask

  task automatic idle_inputs();
    wr_en = 0; wr_offset = 0; wr_data = 0;
    fill_valid = 0; fill_data = 0; fill_tag = 0;
    evict_start = 0; evict_ready = 0;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    #2;
    model_reset();
    check_all(tag);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  task automatic fill(input logic [31:0] d, input logic [2:0] t);
    idle_inputs(); fill_valid = 1; fill_data = d; fill_tag = t;
    step("fill");
    idle_inputs();
  endtask

  task automatic wr(input logic [1:0] o, input logic [7:0] d);
    idle_inputs(); wr_en = 1; wr_offset = o; wr_data = d;
    step("wr");
    idle_inputs();
  endtask

  initial begin
    int pulses_before, bytes_before;
    idle_inputs();
    model_reset();
    m_etag = '0;
    reset_n = 1'b1;
    #1;
    do_reset("reset");

    // 1-2: fill then byte writes
    fill(32'hDDCCBBAA, 3'd5);
    check("t1.block", block_data, 32'hDDCCBBAA);
    wr(2'd2, 8'h11);
    check("t2.block_a", block_data, 32'hDD11BBAA);
    wr(2'd0, 8'h22);
    check("t2.block_b", block_data, 32'hDD11BB22);

    // 3: write-back with ready always high
    pulses_before = done_pulses; bytes_before = ev_bytes;
    evict_start = 1; evict_ready = 1;
    step("t3.start");
    evict_start = 0;
    for (int i = 0; i < 4; i++) step("t3.xfer");
    evict_ready = 0;
    step("t3.after");
    check("t3.bytes", ev_bytes - bytes_before, 4);
    check("t3.pulses", done_pulses - pulses_before, 1);
    check("t3.dirty", dirty, 0);

    // 4: back-pressure on offset 1, ignored requests during EVICT
    wr(2'd1, 8'h5A);
    bytes_before = ev_bytes;
    evict_start = 1; evict_ready = 1;
    step("t4.start");
    evict_start = 0;
    step("t4.x0");
    evict_ready = 0; wr_en = 1; wr_offset = 2'd3; wr_data = 8'hEE;
    fill_valid = 1; fill_data = 32'h12345678; fill_tag = 3'd2;
    step("t4.hold0");
    step("t4.hold1");
    check("t4.held", evict_data, 8'h5A);
    idle_inputs(); evict_ready = 1;
    for (int i = 0; i < 3; i++) step("t4.xfer");
    idle_inputs();
    step("t4.after");
    check("t4.bytes", ev_bytes - bytes_before, 4);
    check("t4.block", block_data, 32'hDD115A22);

    // 5: clean block and invalid block evicts, write to invalid block
    fill(32'h01020304, 3'd1);
    evict_start = 1; step("t5.clean"); idle_inputs();
    check("t5.clean_done", evict_done, 1);
    step("t5.clean_after");
    do_reset("t5.reset");
    evict_start = 1; step("t5.inval"); idle_inputs();
    wr(2'd3, 8'h99);
    check("t5.wr_invalid", block_data, 32'h0);

    // 6: fill has priority; reset mid-evict after two transfers
    fill(32'hCAFEF00D, 3'd6);
    wr(2'd1, 8'h77);
    idle_inputs(); fill_valid = 1; fill_data = 32'hA1B2C3D4; fill_tag = 3'd3;
    evict_start = 1; wr_en = 1; wr_offset = 2'd0; wr_data = 8'h55;
    step("t6.prio");
    idle_inputs();
    check("t6.prio_block", block_data, 32'hA1B2C3D4);
    wr(2'd2, 8'h66);
    evict_start = 1; evict_ready = 1; step("t6.start"); evict_start = 0;
    step("t6.x0"); step("t6.x1");
    pulses_before = done_pulses;
    do_reset("t6.midreset");
    idle_inputs();
    step("t6.post");
    check("t6.nodone", done_pulses - pulses_before, 0);

    // Randomized traffic
    for (int n = 0; n < 2000; n++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset("rnd.reset");
      end else begin
        fill_valid  = ($urandom_range(0, 7) == 0);
        fill_data   = $urandom;
        fill_tag    = 3'($urandom);
        evict_start = ($urandom_range(0, 5) == 0);
        evict_ready = ($urandom_range(0, 2) != 0);
        wr_en       = ($urandom_range(0, 1) == 0);
        wr_offset   = 2'($urandom);
        wr_data     = 8'($urandom);
        step("rnd");
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
